// File: rtl/adsr_voice_mixer.sv
// -----------------------------------------------------------------------------
// adsr_voice_mixer
//
// Purpose:
//   NUM_VOICES independent gated envelopes (IDLE/ATTACK/SUSTAIN/RELEASE), each
//   scaling its own unsigned voice sample. The scaled voices are summed and
//   divided by the number of active voices, so perceived amplitude stays
//   roughly constant as notes are added or dropped. Sits between note decode
//   and the DAC output byte.
//
// Ports:
//   clk           in   system clock, all state on posedge
//   reset_n       in   asynchronous active-low reset
//   voice_sample  in   packed unsigned samples, voice i at [i*SAMPLE_W +: SAMPLE_W]
//   voice_gate    in   per-voice key-held gate, synchronous to clk
//   mix_out       out  normalised mix (registered, 2 clk after gain/sample change)
//   voice_active  out  per-voice "state is not IDLE", straight from state regs
//   active_count  out  number of non-IDLE voices, stage-1 registered
// -----------------------------------------------------------------------------
module adsr_voice_mixer #(
    parameter int NUM_VOICES  = 3,
    parameter int SAMPLE_W    = 8,
    parameter int GAIN_W      = 8,
    parameter int TICK_DIV    = 625000,
    parameter int ATTACK_INC  = 8,
    parameter int RELEASE_DEC = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
    input  logic [NUM_VOICES-1:0]          voice_gate,
    output logic [SAMPLE_W-1:0]            mix_out,
    output logic [NUM_VOICES-1:0]          voice_active,
    output logic [3:0]                     active_count
);

    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int PROD_W = SAMPLE_W + GAIN_W;
    localparam int SUM_W  = SAMPLE_W + 3;
    localparam int RCP_W  = 17;
    localparam int MIXP_W = SUM_W + RCP_W;

    localparam logic [GAIN_W-1:0]   GMAX     = {GAIN_W{1'b1}};
    localparam logic [SAMPLE_W-1:0] MIX_MAX  = {SAMPLE_W{1'b1}};
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Saturating attack step; the sum is formed 32 bits wide so it cannot wrap.
    function automatic logic [GAIN_W-1:0] f_attack_step(input logic [GAIN_W-1:0] g);
        logic [31:0] t;
        t = 32'(g) + 32'(ATTACK_INC);
        if (t >= 32'(GMAX)) begin
            return GMAX;
        end else begin
            return GAIN_W'(t);
        end
    endfunction

    // Saturating release step, floors at zero.
    function automatic logic [GAIN_W-1:0] f_release_step(input logic [GAIN_W-1:0] g);
        if (32'(g) <= 32'(RELEASE_DEC)) begin
            return {GAIN_W{1'b0}};
        end else begin
            return g - GAIN_W'(RELEASE_DEC);
        end
    endfunction

    // floor(65536/k): multiplying by this and shifting by 16 divides by k.
    function automatic logic [RCP_W-1:0] f_recip(input logic [3:0] k);
        case (k)
            4'd1:    return 17'd65536;
            4'd2:    return 17'd32768;
            4'd3:    return 17'd21845;
            4'd4:    return 17'd16384;
            4'd5:    return 17'd13107;
            4'd6:    return 17'd10922;
            4'd7:    return 17'd9362;
            4'd8:    return 17'd8192;
            default: return 17'd0;
        endcase
    endfunction

    logic [CNT_W-1:0]      r_cnt;
    logic [NUM_VOICES-1:0] r_gate_q;
    state_t                r_state  [NUM_VOICES];
    logic [GAIN_W-1:0]     r_gain   [NUM_VOICES];
    logic [SAMPLE_W-1:0]   r_scaled [NUM_VOICES];
    logic [3:0]            r_count;
    logic [SAMPLE_W-1:0]   r_mix;

    logic                  w_tick;
    logic [NUM_VOICES-1:0] w_rise;
    logic [NUM_VOICES-1:0] w_fall;
    logic [NUM_VOICES-1:0] w_active;
    logic [PROD_W-1:0]     w_prod   [NUM_VOICES];
    logic [3:0]            w_count;
    logic [SUM_W-1:0]      w_sum;
    logic [MIXP_W-1:0]     w_mix_prod;
    logic [SAMPLE_W-1:0]   w_mix_next;

    assign w_tick = (r_cnt == CNT_LAST);
    assign w_rise = voice_gate & ~r_gate_q;
    assign w_fall = ~voice_gate & r_gate_q;

    // Envelope tick prescaler: counts 0..TICK_DIV-1 and wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_tick) begin
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Per-voice envelope FSM and gain; gate edges win over the tick and hold gain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gate_q <= {NUM_VOICES{1'b0}};
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_state[i] <= ST_IDLE;
                r_gain[i]  <= {GAIN_W{1'b0}};
            end
        end else begin
            r_gate_q <= voice_gate;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (w_rise[i]) begin
                    // Retrigger keeps the current gain so there is no click.
                    r_state[i] <= ST_ATTACK;
                end else if (w_fall[i] &&
                             (r_state[i] == ST_ATTACK || r_state[i] == ST_SUSTAIN)) begin
                    r_state[i] <= ST_RELEASE;
                end else begin
                    case (r_state[i])
                        ST_IDLE: begin
                            r_gain[i] <= {GAIN_W{1'b0}};
                        end
                        ST_ATTACK: begin
                            if (w_tick) begin
                                r_gain[i] <= f_attack_step(r_gain[i]);
                                if (f_attack_step(r_gain[i]) == GMAX) begin
                                    r_state[i] <= ST_SUSTAIN;
                                end else begin
                                    r_state[i] <= ST_ATTACK;
                                end
                            end else begin
                                r_gain[i] <= r_gain[i];
                            end
                        end
                        ST_SUSTAIN: begin
                            r_gain[i] <= GMAX;
                        end
                        ST_RELEASE: begin
                            if (w_tick) begin
                                r_gain[i] <= f_release_step(r_gain[i]);
                                if (f_release_step(r_gain[i]) == {GAIN_W{1'b0}}) begin
                                    r_state[i] <= ST_IDLE;
                                end else begin
                                    r_state[i] <= ST_RELEASE;
                                end
                            end else begin
                                r_gain[i] <= r_gain[i];
                            end
                        end
                        default: begin
                            r_state[i] <= ST_IDLE;
                            r_gain[i]  <= {GAIN_W{1'b0}};
                        end
                    endcase
                end
            end
        end
    end

    // Active flags, per-voice products and active-voice population count.
    always_comb begin
        w_count = 4'd0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_active[i] = (r_state[i] != ST_IDLE);
            w_prod[i]   = PROD_W'(voice_sample[i*SAMPLE_W +: SAMPLE_W]) * PROD_W'(r_gain[i]);
            w_count     = w_count + {3'd0, w_active[i]};
        end
    end

    // Stage 1: scaled voices (product >> GAIN_W, truncating) and active count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 4'd0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_scaled[i] <= {SAMPLE_W{1'b0}};
            end
        end else begin
            r_count <= w_count;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_scaled[i] <= SAMPLE_W'(w_prod[i] >> GAIN_W);
            end
        end
    end

    // Sum of stage-1 voices, divided by the stage-1 active count and clamped.
    always_comb begin
        w_sum = {SUM_W{1'b0}};
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_sum = w_sum + SUM_W'(r_scaled[i]);
        end
        w_mix_prod = MIXP_W'(w_sum) * MIXP_W'(f_recip(r_count));
        if (r_count == 4'd0) begin
            w_mix_next = {SAMPLE_W{1'b0}};
        end else if ((w_mix_prod >> 16) > MIXP_W'(MIX_MAX)) begin
            w_mix_next = MIX_MAX;
        end else begin
            w_mix_next = SAMPLE_W'(w_mix_prod >> 16);
        end
    end

    // Stage 2: registered mix output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mix <= {SAMPLE_W{1'b0}};
        end else begin
            r_mix <= w_mix_next;
        end
    end

    assign mix_out      = r_mix;
    assign voice_active = w_active;
    assign active_count = r_count;

endmodule

// File: tb/tb_adsr_voice_mixer.sv
// -----------------------------------------------------------------------------
// tb_adsr_voice_mixer
//
// Directed envelope/normalisation scenarios followed by random gate/sample
// traffic. A behavioural model tracks gains, envelope phases and the two-stage
// output pipeline with plain integer arithmetic and is compared every cycle.
// -----------------------------------------------------------------------------
module tb_adsr_voice_mixer;

    localparam int NV = 3;
    localparam int SW = 8;
    localparam int GW = 8;
    localparam int TD = 4;
    localparam int AI = 64;
    localparam int RD = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NV*SW-1:0]  voice_sample = '0;
    logic [NV-1:0]     voice_gate = '0;
    logic [SW-1:0]     mix_out;
    logic [NV-1:0]     voice_active;
    logic [3:0]        active_count;

    adsr_voice_mixer #(
        .NUM_VOICES (NV),
        .SAMPLE_W   (SW),
        .GAIN_W     (GW),
        .TICK_DIV   (TD),
        .ATTACK_INC (AI),
        .RELEASE_DEC(RD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .voice_sample(voice_sample),
        .voice_gate  (voice_gate),
        .mix_out     (mix_out),
        .voice_active(voice_active),
        .active_count(active_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: phase 0=idle 1=attack 2=sustain 3=release
    int m_gain  [NV];
    int m_phase [NV];
    int m_gq    [NV];
    int m_cnt;
    int m_s1sum;
    int m_s1cnt;
    int m_mix;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_gain[v] = 0; m_phase[v] = 0; m_gq[v] = 0;
        end
        m_cnt = 0; m_s1sum = 0; m_s1cnt = 0; m_mix = 0;
    endtask

    task automatic model_edge();
        int  smp, nsum, ncnt, q, g;
        bit  tick;
        tick = (m_cnt == TD - 1);
        if (m_s1cnt == 0) begin
            m_mix = 0;
        end else begin
            q = (m_s1sum * (65536 / m_s1cnt)) >>> 16;
            m_mix = (q > 255) ? 255 : q;
        end
        nsum = 0; ncnt = 0;
        for (int v = 0; v < NV; v++) begin
            smp  = int'(voice_sample[v*SW +: SW]);
            nsum = nsum + ((smp * m_gain[v]) >>> GW);
            if (m_phase[v] != 0) ncnt++;
        end
        m_s1sum = nsum; m_s1cnt = ncnt;
        for (int v = 0; v < NV; v++) begin
            g = int'(voice_gate[v]);
            if (g == 1 && m_gq[v] == 0) begin
                m_phase[v] = 1;
            end else if (g == 0 && m_gq[v] == 1 && (m_phase[v] == 1 || m_phase[v] == 2)) begin
                m_phase[v] = 3;
            end else if (tick && m_phase[v] == 1) begin
                m_gain[v] = (m_gain[v] + AI > 255) ? 255 : m_gain[v] + AI;
                if (m_gain[v] == 255) m_phase[v] = 2;
            end else if (tick && m_phase[v] == 3) begin
                m_gain[v] = (m_gain[v] - RD < 0) ? 0 : m_gain[v] - RD;
                if (m_gain[v] == 0) m_phase[v] = 0;
            end
            m_gq[v] = g;
        end
        m_cnt = tick ? 0 : m_cnt + 1;
    endtask

    task automatic check_outputs();
        logic [NV-1:0] exp_act;
        for (int v = 0; v < NV; v++) exp_act[v] = (m_phase[v] != 0);
        check("mix_out", 32'(mix_out), 32'(m_mix));
        check("voice_active", 32'(voice_active), 32'(exp_act));
        check("active_count", 32'(active_count), 32'(m_s1cnt));
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) model_edge(); else model_reset();
        #1;
        check_outputs();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int seen[$];
        int attack_exp[4];
        int guard;
        attack_exp[0] = 50; attack_exp[1] = 100; attack_exp[2] = 150; attack_exp[3] = 199;

        // Reset state
        model_reset();
        #12;
        check("rst_mix", 32'(mix_out), 32'd0);
        check("rst_active", 32'(voice_active), 32'd0);
        check("rst_count", 32'(active_count), 32'd0);
        reset_n = 1'b1;
        steps(3);

        // 1. Attack on voice 0
        voice_sample = 24'd200;
        voice_gate   = 3'b001;
        for (int i = 0; i < 24; i++) begin
            step();
            if (mix_out != 8'd0 && (seen.size() == 0 || seen[seen.size()-1] != int'(mix_out)))
                seen.push_back(int'(mix_out));
        end
        check("attack_nvals", 32'(seen.size()), 32'd4);
        for (int i = 0; i < 4 && i < seen.size(); i++)
            check("attack_seq", 32'(seen[i]), 32'(attack_exp[i]));
        check("sustain_mix", 32'(mix_out), 32'd199);
        check("sustain_active", 32'(voice_active), 32'b001);
        check("sustain_count", 32'(active_count), 32'd1);

        // 2. Release to idle
        voice_gate = 3'b000;
        steps(40);
        check("release_mix", 32'(mix_out), 32'd0);
        check("release_active", 32'(voice_active), 32'd0);

        // 3. Retrigger during release at gain 127
        voice_gate = 3'b001;
        steps(24);
        voice_gate = 3'b000;
        guard = 0;
        while (m_gain[0] != 127 && guard < 40) begin step(); guard++; end
        check("retrig_reach127", 32'(m_gain[0] == 127), 32'd1);
        voice_gate = 3'b001;
        guard = 0;
        while (m_gain[0] == 127 && guard < 10) begin step(); guard++; end
        check("retrig_active", 32'(voice_active[0]), 32'd1);
        steps(2);
        check("retrig_mix191", 32'(mix_out), 32'd149);

        // 4. Normalisation
        voice_sample = {8'd255, 8'd255, 8'd255};
        voice_gate   = 3'b111;
        steps(30);
        check("norm3_mix", 32'(mix_out), 32'd253);
        check("norm3_count", 32'(active_count), 32'd3);
        voice_sample = {8'd255, 8'd200, 8'd100};
        voice_gate   = 3'b011;
        steps(50);
        check("norm2_mix", 32'(mix_out), 32'd149);
        check("norm2_count", 32'(active_count), 32'd2);
        check("norm2_active", 32'(voice_active), 32'b011);

        // 5. Rise on voice 2 in the same cycle as a tick: gain must stay 0
        guard = 0;
        while (m_cnt != TD - 1 && guard < 8) begin step(); guard++; end
        voice_gate = 3'b111;
        step();
        check("rise_tick_active", 32'(voice_active), 32'b111);
        steps(2);
        check("rise_tick_mix", 32'(mix_out), 32'd99);

        // 6. Async reset mid-attack
        voice_gate = 3'b000;
        steps(50);
        voice_sample = 24'd200;
        voice_gate   = 3'b001;
        steps(10);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_mix", 32'(mix_out), 32'd0);
        check("async_active", 32'(voice_active), 32'd0);
        check("async_count", 32'(active_count), 32'd0);
        model_reset();
        steps(2);
        reset_n = 1'b1;
        steps(5);
        check("post_rst_before_tick", 32'(mix_out), 32'd0);
        step();
        check("post_rst_first_tick", 32'(mix_out), 32'd50);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) voice_sample = NV*SW'($urandom);
            for (int v = 0; v < NV; v++)
                if ($urandom_range(0, 11) == 0) voice_gate[v] = ~voice_gate[v];
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/adsr_voice_mixer.md
Name: adsr_voice_mixer

Overview:
- Parametrised successor to the fixed three-note attenuation-and-mix path of the keyboard synth.
- NUM_VOICES independent gated envelopes (IDLE/ATTACK/SUSTAIN/RELEASE), each scaling its own unsigned voice sample.
- Mixes the active voices and normalises by the number of active voices, so perceived amplitude stays constant.
- Sits between the note-decode logic (voice samples and gates) and the DAC output byte.

Parameters:
- NUM_VOICES, 3: number of voices; legal range 1..8.
- SAMPLE_W, 8: width of voice samples and of mix_out; unsigned.
- GAIN_W, 8: envelope gain width; GMAX = 2^GAIN_W-1.
- TICK_DIV, 625000: clk cycles per envelope tick; must be at least 2.
- ATTACK_INC, 8: gain added per tick in ATTACK.
- RELEASE_DEC, 2: gain subtracted per tick in RELEASE.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- voice_sample  in  NUM_VOICES*SAMPLE_W  packed unsigned samples; voice i is at [i*SAMPLE_W +: SAMPLE_W].
- voice_gate  in  NUM_VOICES  1 = key held, per voice; synchronous to clk.
- mix_out  out  SAMPLE_W  normalised mix.
- voice_active  out  NUM_VOICES  1 = voice state is not IDLE.
- active_count  out  4  number of voices not IDLE, taken from stage-1.

Behaviour:
- Reset (reset_n=0, async):
  - Tick prescaler = 0; all gains = 0; all states = IDLE; gate history = 0.
  - Pipeline registers = 0; mix_out = 0, voice_active = 0, active_count = 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = 1 for one clk when count == TICK_DIV-1.
- Gate edges: gate_q registers voice_gate. rise = gate & ~gate_q; fall = ~gate & gate_q.
- Per-voice FSM, evaluated every clk; edges take priority over tick:
  - rise, any state -> ATTACK; gain held this cycle. Retrigger continues from the current gain.
  - fall, in ATTACK or SUSTAIN -> RELEASE; gain held this cycle.
  - fall while IDLE: ignored.
  - ATTACK on tick: gain = min(gain+ATTACK_INC, GMAX). If the result is GMAX, go to SUSTAIN.
  - SUSTAIN: gain holds at GMAX while the gate stays high.
  - RELEASE on tick: gain = max(gain-RELEASE_DEC, 0). If the result is 0, go to IDLE.
  - A gate fall before the first attack tick (gain 0) enters RELEASE, then reaches IDLE on the next tick.
  - IDLE: gain = 0.
- Stage 1 (registered):
  - scaled_i = (sample_i * gain_i) >> GAIN_W, SAMPLE_W bits, truncating.
  - active_count = popcount(state != IDLE).
  - voice_active comes from the state registers directly, with no stage delay.
- Stage 2 (registered):
  - sum = sum of scaled_i, width SAMPLE_W + 3.
  - RECIP[k] = floor(65536/k), 17-bit constant table for k = 1..8.
  - mix_out = (k == 0) ? 0 : min((sum * RECIP[k]) >> 16, 2^SAMPLE_W-1).
- Latency: a gain or sample change appears on mix_out 2 clk later.
- Arithmetic: no wrap anywhere. Gain saturates at 0 and GMAX; mix_out is clamped.
- Reset mid-envelope returns everything to the reset values immediately, with no fade.

Test Plan (TICK_DIV=4, ATTACK_INC=64, RELEASE_DEC=32, defaults otherwise):
1. Attack, single voice.
   - Stimulus: sample0=200, gate0 rises.
   - Gains on successive ticks: 64, 128, 192, 255; state reaches SUSTAIN.
   - mix_out sequence: 50, 100, 150, 199, each 2 clk after its tick.
   - voice_active=001; active_count=1.
2. Release.
   - Stimulus: gate0 falls while in SUSTAIN.
   - Gain sequence: 223, 191, 159, 127, 95, 63, 31, 0.
   - At 0: IDLE, voice_active=000, mix_out=0 two clk later.
3. Retrigger.
   - Stimulus: gate0 rises again during RELEASE at gain 127.
   - Next tick gives gain 191; no reset to 0; state ATTACK.
4. Normalisation.
   - Three voices, all samples 255, all in SUSTAIN: scaled = 254 each, sum = 762.
   - mix_out = (762*21845)>>16 = 253.
   - Two voices, samples 100 and 200, at GMAX: sum 99+199 = 298; mix_out = 149.
5. Simultaneous events.
   - gate rise in the same cycle as tick: state becomes ATTACK, gain unchanged that cycle.
   - Fall while IDLE: no change.
6. Async reset.
   - Stimulus: drop reset_n mid-attack, between clk edges.
   - mix_out, voice_active and active_count go to 0 without waiting for a clock edge.
   - After release of reset: first tick occurs TICK_DIV clk after the first edge.
